// File: rtl/bernoulli_noise_array.sv
// Parametrised Bernoulli noise source: NUM_CH Galois-LFSR channels compared against a shared threshold.
// Optional NOISE_STATS_EN adds a saturating popcount accumulator (stat_clr / ones_cnt).
module bernoulli_noise_array #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned RAND_W     = 8,
  parameter int unsigned WARMUP_CYC = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cfg_load,
  input  logic [31:0]       cfg_seed,
  input  logic [RAND_W:0]   cfg_threshold,
  input  logic              enable,
  output logic [NUM_CH-1:0] noise,
  output logic              noise_valid,
  output logic              busy
`ifdef NOISE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       ones_cnt
`endif
);

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PC_W   = $clog2(NUM_CH + 1);
  localparam logic [LFSR_W-1:0] POLY_MASK = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] SEED_MUL  = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_RUN
  } state_t;

  // Right-shifting Galois step; feedback applied when the bit shifted out is 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] nx;
    nx = x >> 1;
    if (x[0]) nx = nx ^ POLY_MASK;
    return nx;
  endfunction

  // Decorrelates channels from one base seed; all-zero would lock the LFSR.
  function automatic logic [LFSR_W-1:0] chan_seed(input logic [LFSR_W-1:0] base,
                                                   input int unsigned ch);
    logic [LFSR_W-1:0] mix;
    logic [LFSR_W-1:0] s;
    mix = LFSR_W'(LFSR_W'(ch + 1) * SEED_MUL);
    s   = base ^ mix;
    if (s == '0) s = LFSR_W'(1);
    return s;
  endfunction

  state_t            state;
  logic [LFSR_W-1:0] lfsr [NUM_CH];
  logic [RAND_W:0]   thr_q;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] hit_c;

  // Per-channel Bernoulli decision on the current (pre-step) LFSR value.
  always_comb begin
    hit_c = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      hit_c[ch] = ({1'b0, lfsr[ch][RAND_W-1:0]} < thr_q);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= S_IDLE;
      thr_q       <= '0;
      cnt         <= '0;
      noise       <= '0;
      noise_valid <= 1'b0;
      busy        <= 1'b0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) lfsr[ch] <= LFSR_W'(1);
    end else if (cfg_load) begin
      // Load wins over enable and over warm-up completion.
      for (int unsigned ch = 0; ch < NUM_CH; ch++) lfsr[ch] <= chan_seed(cfg_seed, ch);
      thr_q       <= cfg_threshold;
      cnt         <= '0;
      noise       <= '0;
      noise_valid <= 1'b0;
      if (WARMUP_CYC == 0) begin
        state <= S_RUN;
        busy  <= 1'b0;
      end else begin
        state <= S_WARMUP;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          noise_valid <= 1'b0;
        end
        S_WARMUP: begin
          for (int unsigned ch = 0; ch < NUM_CH; ch++) lfsr[ch] <= lfsr_step(lfsr[ch]);
          cnt         <= cnt + CNT_W'(1);
          noise_valid <= 1'b0;
          if (cnt == CNT_W'(WARMUP_CYC - 1)) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          if (enable) begin
            noise       <= hit_c;
            noise_valid <= 1'b1;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) lfsr[ch] <= lfsr_step(lfsr[ch]);
          end else begin
            noise_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          noise_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef NOISE_STATS_EN
  logic [PC_W-1:0] pop_c;
  logic [32:0]     sum_c;

  always_comb begin
    pop_c = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) pop_c = pop_c + PC_W'(noise[ch]);
    sum_c = {1'b0, ones_cnt} + 33'(pop_c);
  end

  // Accumulates the registered noise word, so the count trails noise by one cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ones_cnt <= '0;
    end else if (stat_clr || cfg_load) begin
      ones_cnt <= '0;
    end else if (noise_valid) begin
      ones_cnt <= sum_c[32] ? 32'hFFFF_FFFF : sum_c[31:0];
    end
  end
`endif

endmodule
